// File: rtl/exception_ctrl.sv
// ============================================================================
// exception_ctrl : precise-exception/interrupt/eret arbiter with timed flush
//                  and PC redirect. Optional exc_count output via EXC_COUNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module exception_ctrl #(
   parameter int          NUM_SRC      = 8,
   parameter int          HW_INT       = 6,
   parameter int          FLUSH_CYCLES = 2,
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 commit_valid,
   input  logic                 stall,
   input  logic [NUM_SRC-1:0]   src_req,
   input  logic [5*NUM_SRC-1:0] src_code,
   input  logic                 eret_req,
   input  logic [HW_INT-1:0]    int_in,
   input  logic [HW_INT-1:0]    int_ack,
   input  logic [31:0]          cp0_status,
   input  logic [31:0]          cp0_cause,
   input  logic [31:0]          cp0_epc,
   input  logic [31:0]          pc_in,
   input  logic                 in_delay_slot,
   input  logic [31:0]          bad_addr,
   output logic                 exc_valid,
   output logic [4:0]           exc_code,
   output logic [31:0]          exc_epc,
   output logic                 exc_bd,
   output logic [31:0]          exc_badvaddr,
   output logic                 flush,
   output logic [31:0]          new_pc,
   output logic                 redirect,
   output logic                 is_eret,
`ifdef EXC_COUNT_EN
   output logic [31:0]          exc_count,
`endif
   output logic [HW_INT-1:0]    int_pending
);

   localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_FLUSH = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               exc_valid_q, exc_valid_d;
   logic [4:0]         exc_code_q, exc_code_d;
   logic [31:0]        exc_epc_q, exc_epc_d;
   logic               exc_bd_q, exc_bd_d;
   logic [31:0]        exc_badvaddr_q, exc_badvaddr_d;
   logic               flush_q, flush_d;
   logic [31:0]        new_pc_q, new_pc_d;
   logic               redirect_q, redirect_d;
   logic               is_eret_q, is_eret_d;
   logic [HW_INT-1:0]  sync1_q, sync2_q, sync3_q;
   logic [HW_INT-1:0]  pend_q, pend_d;
`ifdef EXC_COUNT_EN
   logic [31:0]        count_q, count_d;
`endif

   logic [7:0]         w_ip;
   logic               w_int_take;
   logic               w_src_hit;
   logic [4:0]         w_src_code;
   logic [4:0]         w_sel_code;

   // sync3 holds the previous synchronized value for rising-edge detection
   assign pend_d = (pend_q & ~int_ack) | (sync2_q & ~sync3_q);

   always_comb begin
      w_ip      = '0;
      w_ip[1:0] = cp0_cause[9:8];
      for (int i = 0; i < HW_INT; i++) begin
         w_ip[i+2] = pend_q[i];
      end
   end

   assign w_int_take = (|(w_ip & cp0_status[15:8])) && !cp0_status[1]
                       && cp0_status[0] && commit_valid;

   // Scan from lowest to highest priority so index 0 wins
   always_comb begin
      w_src_hit  = 1'b0;
      w_src_code = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (src_req[i]) begin
            w_src_hit  = 1'b1;
            w_src_code = src_code[5*i +: 5];
         end
      end
   end

   assign w_sel_code = w_int_take ? 5'h00 : w_src_code;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      exc_valid_d    = 1'b0;
      redirect_d     = 1'b0;
      is_eret_d      = 1'b0;
      flush_d        = flush_q;
      exc_code_d     = exc_code_q;
      exc_epc_d      = exc_epc_q;
      exc_bd_d       = exc_bd_q;
      exc_badvaddr_d = exc_badvaddr_q;
      new_pc_d       = new_pc_q;
`ifdef EXC_COUNT_EN
      count_d        = count_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (commit_valid && !stall && (w_int_take || w_src_hit || eret_req)) begin
               state_d    = S_FLUSH;
               cnt_d      = CNT_W'(1);
               flush_d    = 1'b1;
               redirect_d = 1'b1;
               if (w_int_take || w_src_hit) begin
                  exc_valid_d    = 1'b1;
                  exc_code_d     = w_sel_code;
                  exc_epc_d      = in_delay_slot ? (pc_in - 32'd4) : pc_in;
                  exc_bd_d       = in_delay_slot;
                  exc_badvaddr_d = (w_sel_code == 5'h04 || w_sel_code == 5'h05)
                                   ? bad_addr : 32'd0;
                  new_pc_d       = EXC_VECTOR;
`ifdef EXC_COUNT_EN
                  if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
`endif
               end else begin
                  is_eret_d = 1'b1;
                  new_pc_d  = cp0_epc;
               end
            end
         end
         S_FLUSH: begin
            if (cnt_q == CNT_W'(FLUSH_CYCLES)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               flush_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            flush_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         exc_valid_q    <= 1'b0;
         exc_code_q     <= '0;
         exc_epc_q      <= '0;
         exc_bd_q       <= 1'b0;
         exc_badvaddr_q <= '0;
         flush_q        <= 1'b0;
         new_pc_q       <= '0;
         redirect_q     <= 1'b0;
         is_eret_q      <= 1'b0;
         sync1_q        <= '0;
         sync2_q        <= '0;
         sync3_q        <= '0;
         pend_q         <= '0;
`ifdef EXC_COUNT_EN
         count_q        <= '0;
`endif
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         exc_valid_q    <= exc_valid_d;
         exc_code_q     <= exc_code_d;
         exc_epc_q      <= exc_epc_d;
         exc_bd_q       <= exc_bd_d;
         exc_badvaddr_q <= exc_badvaddr_d;
         flush_q        <= flush_d;
         new_pc_q       <= new_pc_d;
         redirect_q     <= redirect_d;
         is_eret_q      <= is_eret_d;
         sync1_q        <= int_in;
         sync2_q        <= sync1_q;
         sync3_q        <= sync2_q;
         pend_q         <= pend_d;
`ifdef EXC_COUNT_EN
         count_q        <= count_d;
`endif
      end
   end

   assign exc_valid    = exc_valid_q;
   assign exc_code     = exc_code_q;
   assign exc_epc      = exc_epc_q;
   assign exc_bd       = exc_bd_q;
   assign exc_badvaddr = exc_badvaddr_q;
   assign flush        = flush_q;
   assign new_pc       = new_pc_q;
   assign redirect     = redirect_q;
   assign is_eret      = is_eret_q;
   assign int_pending  = pend_q;
`ifdef EXC_COUNT_EN
   assign exc_count    = count_q;
`endif

   logic w_unused;
   assign w_unused = ^{cp0_status[31:16], cp0_status[7:2], cp0_cause[31:10], cp0_cause[7:0]};

endmodule

`default_nettype wire

// File: tb/tb_exception_ctrl.sv
// Directed testbench for exception_ctrl (default parameters).
`default_nettype none

module tb_exception_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        commit_valid, stall, eret_req, in_delay_slot;
   logic [7:0]  src_req;
   logic [39:0] src_code;
   logic [5:0]  int_in, int_ack;
   logic [31:0] cp0_status, cp0_cause, cp0_epc, pc_in, bad_addr;
   logic        exc_valid, exc_bd, flush, redirect, is_eret;
   logic [4:0]  exc_code;
   logic [31:0] exc_epc, exc_badvaddr, new_pc;
   logic [5:0]  int_pending;
`ifdef EXC_COUNT_EN
   logic [31:0] exc_count;
`endif

   int checks   = 0;
   int failures = 0;

   exception_ctrl dut (
      .clk(clk), .rst(rst), .commit_valid(commit_valid), .stall(stall),
      .src_req(src_req), .src_code(src_code), .eret_req(eret_req),
      .int_in(int_in), .int_ack(int_ack), .cp0_status(cp0_status),
      .cp0_cause(cp0_cause), .cp0_epc(cp0_epc), .pc_in(pc_in),
      .in_delay_slot(in_delay_slot), .bad_addr(bad_addr),
      .exc_valid(exc_valid), .exc_code(exc_code), .exc_epc(exc_epc),
      .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr), .flush(flush),
      .new_pc(new_pc), .redirect(redirect), .is_eret(is_eret),
`ifdef EXC_COUNT_EN
      .exc_count(exc_count),
`endif
      .int_pending(int_pending)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      commit_valid = 0; stall = 0; eret_req = 0; in_delay_slot = 0;
      src_req = '0; src_code = '0; int_in = '0; int_ack = '0;
      pc_in = '0; bad_addr = '0; cp0_epc = '0;
   endtask

   initial begin
      rst = 1; cp0_status = '0; cp0_cause = '0;
      idle_inputs();
      tick(); tick();
      rst = 0;
      chk("reset_exc_valid", {31'd0, exc_valid}, 32'd0);
      chk("reset_flush", {31'd0, flush}, 32'd0);
      chk("reset_new_pc", new_pc, 32'd0);
      chk("reset_pending", {26'd0, int_pending}, 32'd0);

      // Single source exception, source 2
      commit_valid = 1; src_req = 8'b0000_0100; src_code[14:10] = 5'h0c;
      pc_in = 32'h8000_0010;
      tick();
      idle_inputs();
      chk("t1_valid", {31'd0, exc_valid}, 32'd1);
      chk("t1_code", {27'd0, exc_code}, 32'h0c);
      chk("t1_epc", exc_epc, 32'h8000_0010);
      chk("t1_newpc", new_pc, 32'hBFC00380);
      chk("t1_redirect", {31'd0, redirect}, 32'd1);
      chk("t1_flush0", {31'd0, flush}, 32'd1);
      chk("t1_badv", exc_badvaddr, 32'd0);
      tick();
      chk("t1_valid_drop", {31'd0, exc_valid}, 32'd0);
      chk("t1_redirect_drop", {31'd0, redirect}, 32'd0);
      chk("t1_flush1", {31'd0, flush}, 32'd1);
      tick();
      chk("t1_flush_end", {31'd0, flush}, 32'd0);
      chk("t1_code_hold", {27'd0, exc_code}, 32'h0c);

      // Two sources, delay slot, address error wins
      commit_valid = 1; src_req = 8'b0000_1010;
      src_code[9:5] = 5'h04; src_code[19:15] = 5'h08;
      in_delay_slot = 1; pc_in = 32'h100; bad_addr = 32'h1233;
      tick();
      idle_inputs();
      chk("t2_code", {27'd0, exc_code}, 32'h04);
      chk("t2_epc", exc_epc, 32'hFC);
      chk("t2_bd", {31'd0, exc_bd}, 32'd1);
      chk("t2_badv", exc_badvaddr, 32'h1233);
      tick(); tick();

      // Interrupt on line 0 (IM2 enabled, IE=1, EXL=0)
      cp0_status = 32'h0000_0401;
      int_in[0] = 1;
      tick();
      int_in[0] = 0;
      tick();
      chk("i1_pend_early", {26'd0, int_pending}, 32'd0);
      tick();
      chk("i1_pend", {26'd0, int_pending}, 32'd1);
      commit_valid = 1; pc_in = 32'h200;
      tick();
      commit_valid = 0;
      chk("i1_valid", {31'd0, exc_valid}, 32'd1);
      chk("i1_code", {27'd0, exc_code}, 32'h00);
      chk("i1_epc", exc_epc, 32'h200);
      tick(); tick();
      int_ack[0] = 1;
      tick();
      int_ack[0] = 0;
      chk("i1_ack", {26'd0, int_pending}, 32'd0);

      // Same with EXL=1: pending latches but no event
      cp0_status = 32'h0000_0403;
      int_in[0] = 1;
      tick();
      int_in[0] = 0;
      tick(); tick();
      chk("i2_pend", {26'd0, int_pending}, 32'd1);
      commit_valid = 1;
      tick();
      commit_valid = 0;
      chk("i2_no_valid", {31'd0, exc_valid}, 32'd0);
      chk("i2_no_flush", {31'd0, flush}, 32'd0);
      int_ack[0] = 1;
      tick();
      int_ack[0] = 0;
      chk("i2_ack", {26'd0, int_pending}, 32'd0);
      cp0_status = '0;

      // Eret held off by stall
      eret_req = 1; commit_valid = 1; cp0_epc = 32'h8000_0200; stall = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("e_stall_redirect", {31'd0, redirect}, 32'd0);
         chk("e_stall_flush", {31'd0, flush}, 32'd0);
      end
      stall = 0;
      tick();
      idle_inputs();
      chk("e_is_eret", {31'd0, is_eret}, 32'd1);
      chk("e_newpc", new_pc, 32'h8000_0200);
      chk("e_valid", {31'd0, exc_valid}, 32'd0);
      chk("e_redirect", {31'd0, redirect}, 32'd1);
      tick();
      chk("e_is_eret_drop", {31'd0, is_eret}, 32'd0);
      tick();

      // New request during flush is ignored
      commit_valid = 1; src_req = 8'b0000_0001; src_code[4:0] = 5'h0d; pc_in = 32'h400;
      tick();
      chk("f_code", {27'd0, exc_code}, 32'h0d);
      src_code[4:0] = 5'h0a;
      tick();
      idle_inputs();
      chk("f_ignored_valid", {31'd0, exc_valid}, 32'd0);
      chk("f_ignored_code", {27'd0, exc_code}, 32'h0d);
      tick();
      chk("f_done", {31'd0, flush}, 32'd0);

      // Reset in the first flush cycle
      commit_valid = 1; src_req = 8'b0000_0001; src_code[4:0] = 5'h0a; pc_in = 32'h500;
      tick();
      idle_inputs();
      chk("r_flush_on", {31'd0, flush}, 32'd1);
      rst = 1;
      tick();
      rst = 0;
      chk("r_flush", {31'd0, flush}, 32'd0);
      chk("r_code", {27'd0, exc_code}, 32'd0);
      chk("r_epc", exc_epc, 32'd0);
      chk("r_newpc", new_pc, 32'd0);
      chk("r_valid", {31'd0, exc_valid}, 32'd0);
      commit_valid = 1; src_req = 8'b0000_0001; src_code[4:0] = 5'h0c;
      tick();
      idle_inputs();
      chk("r_idle_take", {31'd0, exc_valid}, 32'd1);
      tick(); tick();

`ifdef EXC_COUNT_EN
      // One exception already counted since reset; add two more and one eret
      for (int k = 0; k < 2; k++) begin
         commit_valid = 1; src_req = 8'b0000_0010; src_code[9:5] = 5'h0a;
         tick();
         idle_inputs();
         tick(); tick();
      end
      commit_valid = 1; eret_req = 1; cp0_epc = 32'h40;
      tick();
      idle_inputs();
      tick(); tick();
      chk("count", exc_count, 32'd3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
